// File: rtl/reset_set_bank.sv
// reset_set_bank
//   Bank of WIDTH independent SR flags. When set and reset arrive together,
//   MODE decides the result. An optional timeout clears a flag after it has
//   been high for TIMEOUT cycles. Each channel also gives one-cycle pulses
//   when its flag rises, falls, or expires.
//
// Ports
//   clk   in   1      clock; all state changes on the rising edge
//   rst   in   1      asynchronous reset, active high
//   s     in   WIDTH  per-channel set request, level sampled each clock
//   r     in   WIDTH  per-channel reset request, level sampled each clock
//   q     out  WIDTH  flag state
//   nq    out  WIDTH  inverse of q
//   rise  out  WIDTH  pulse in the first cycle q[i] is 1
//   fall  out  WIDTH  pulse in the first cycle q[i] is 0
//   expd  out  WIDTH  pulse when q[i] dropped only because its timeout ran out
//   any   out  1      OR of q
//   all   out  1      AND of q
//
// Every output is a register, so there is no combinational path from s/r to
// any output.
module reset_set_bank #(
    parameter int               WIDTH     = 8,
    parameter int               MODE      = 0,
    parameter int               TIMEOUT   = 0,
    parameter int               RETRIGGER = 1,
    parameter logic [WIDTH-1:0] INIT      = {WIDTH{1'b0}},
    parameter int               CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] expd,
    output logic             any,
    output logic             all
);

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] expire;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic q_next_ch;
        logic expire_ch;
        logic r_eff;

        if (TIMEOUT > 0) begin : g_cnt
            logic [CNT_W-1:0] cnt;

            // A count of 1 while the flag is high means this is its last high cycle.
            // A count of 0 never expires, so an INIT=1 channel stays armed until its next set.
            assign expire_ch = q[i] & (cnt == CNT_W'(1));

            // Timeout counter: reload on the rising edge, on expiry and on retrigger; otherwise count down.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt <= {CNT_W{1'b0}};
                end else if (!q_next_ch) begin
                    cnt <= {CNT_W{1'b0}};
                end else if (!q[i] || expire_ch || (s[i] && (RETRIGGER != 0))) begin
                    cnt <= CNT_W'(TIMEOUT);
                end else if (cnt > CNT_W'(1)) begin
                    cnt <= cnt - CNT_W'(1);
                end else begin
                    cnt <= cnt;
                end
            end
        end else begin : g_no_cnt
            assign expire_ch = 1'b0;
        end

        // An expiry behaves exactly like a reset request.
        assign r_eff = r[i] | expire_ch;

        // Next-state decode for one SR channel; MODE resolves set and reset arriving together.
        always_comb begin
            q_next_ch = q[i];
            case ({s[i], r_eff})
                2'b00:   q_next_ch = q[i];
                2'b10:   q_next_ch = 1'b1;
                2'b01:   q_next_ch = 1'b0;
                2'b11: begin
                    case (MODE)
                        0:       q_next_ch = 1'b1;
                        1:       q_next_ch = 1'b0;
                        2:       q_next_ch = q[i];
                        3:       q_next_ch = ~q[i];
                        default: q_next_ch = q[i];
                    endcase
                end
                default: q_next_ch = q[i];
            endcase
        end

        assign q_next[i] = q_next_ch;
        assign expire[i] = expire_ch;
    end

    // Flag state, edge pulses and summary outputs are all registered from q_next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= INIT;
            nq   <= ~INIT;
            rise <= {WIDTH{1'b0}};
            fall <= {WIDTH{1'b0}};
            expd <= {WIDTH{1'b0}};
            any  <= |INIT;
            all  <= &INIT;
        end else begin
            q    <= q_next;
            nq   <= ~q_next;
            rise <= ~q & q_next;
            fall <= q & ~q_next;
            // expd is set only when the timeout alone caused the drop, with no external reset that cycle.
            expd <= q & ~q_next & expire & ~r;
            any  <= |q_next;
            all  <= &q_next;
        end
    end

endmodule

// File: tb/tb_reset_set_bank.sv
// Testbench for reset_set_bank.
//   Five instances cover different parameter sets:
//     0: MODE0, TIMEOUT=4, RETRIGGER=1
//     1: MODE1, INIT=A5
//     2: MODE2
//     3: MODE3
//     4: MODE0, TIMEOUT=4, RETRIGGER=0
//   The stimulus pushes the expected state for each clock into a queue.
//   A monitor pops and compares on the falling edge.
module tb_reset_set_bank;

    localparam int N = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_v    [N];
    logic [7:0] r_v    [N];
    logic [7:0] q_o    [N];
    logic [7:0] nq_o   [N];
    logic [7:0] rise_o [N];
    logic [7:0] fall_o [N];
    logic [7:0] expd_o [N];
    logic       any_o  [N];
    logic       all_o  [N];

    int cyc     = 0;
    int n_vec   = 0;
    int n_miss  = 0;
    bit stim_done = 1'b0;

    typedef struct {
        int         dut;
        int         tag;
        logic [7:0] q;
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] expd;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    reset_set_bank #(.WIDTH(8), .MODE(0), .TIMEOUT(4), .RETRIGGER(1), .INIT(8'h00)) u0 (
        .clk(clk), .rst(rst), .s(s_v[0]), .r(r_v[0]), .q(q_o[0]), .nq(nq_o[0]),
        .rise(rise_o[0]), .fall(fall_o[0]), .expd(expd_o[0]), .any(any_o[0]), .all(all_o[0]));
    reset_set_bank #(.WIDTH(8), .MODE(1), .TIMEOUT(0), .RETRIGGER(1), .INIT(8'hA5)) u1 (
        .clk(clk), .rst(rst), .s(s_v[1]), .r(r_v[1]), .q(q_o[1]), .nq(nq_o[1]),
        .rise(rise_o[1]), .fall(fall_o[1]), .expd(expd_o[1]), .any(any_o[1]), .all(all_o[1]));
    reset_set_bank #(.WIDTH(8), .MODE(2), .TIMEOUT(0), .RETRIGGER(1), .INIT(8'h00)) u2 (
        .clk(clk), .rst(rst), .s(s_v[2]), .r(r_v[2]), .q(q_o[2]), .nq(nq_o[2]),
        .rise(rise_o[2]), .fall(fall_o[2]), .expd(expd_o[2]), .any(any_o[2]), .all(all_o[2]));
    reset_set_bank #(.WIDTH(8), .MODE(3), .TIMEOUT(0), .RETRIGGER(1), .INIT(8'h00)) u3 (
        .clk(clk), .rst(rst), .s(s_v[3]), .r(r_v[3]), .q(q_o[3]), .nq(nq_o[3]),
        .rise(rise_o[3]), .fall(fall_o[3]), .expd(expd_o[3]), .any(any_o[3]), .all(all_o[3]));
    reset_set_bank #(.WIDTH(8), .MODE(0), .TIMEOUT(4), .RETRIGGER(0), .INIT(8'h00)) u4 (
        .clk(clk), .rst(rst), .s(s_v[4]), .r(r_v[4]), .q(q_o[4]), .nq(nq_o[4]),
        .rise(rise_o[4]), .fall(fall_o[4]), .expd(expd_o[4]), .any(any_o[4]), .all(all_o[4]));

    // Direct check, used only for the asynchronous reset values.
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Drive one clock of s/r on a DUT and queue the state expected after that edge.
    task automatic step(input int d, input logic [7:0] sv, input logic [7:0] rv,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic [7:0] ef, input logic [7:0] ee);
        exp_t e;
        s_v[d] = sv;
        r_v[d] = rv;
        e.dut = d; e.tag = cyc + 1; e.q = eq; e.rise = er; e.fall = ef; e.expd = ee;
        sb.push_back(e);
        @(posedge clk);
        #1;
        s_v[d] = 8'h00;
        r_v[d] = 8'h00;
    endtask

    // Idle clocks in which q holds and no pulse is expected.
    task automatic hold(input int d, input int n, input logic [7:0] eq);
        for (int k = 0; k < n; k++) step(d, 8'h00, 8'h00, eq, 8'h00, 8'h00, 8'h00);
    endtask

    // Monitor: compares every queued expectation whose edge has passed.
    initial begin : monitor
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].tag <= cyc) begin
                e = sb.pop_front();
                ok = (q_o[e.dut] === e.q) && (nq_o[e.dut] === ~e.q) &&
                     (rise_o[e.dut] === e.rise) && (fall_o[e.dut] === e.fall) &&
                     (expd_o[e.dut] === e.expd) && (any_o[e.dut] === (|e.q)) &&
                     (all_o[e.dut] === (&e.q));
                n_vec++;
                if (!ok) begin
                    n_miss++;
                    $display("FAIL dut%0d cyc%0d: got q=%h nq=%h rise=%h fall=%h expd=%h any=%b all=%b, expected q=%h rise=%h fall=%h expd=%h",
                             e.dut, cyc, q_o[e.dut], nq_o[e.dut], rise_o[e.dut], fall_o[e.dut],
                             expd_o[e.dut], any_o[e.dut], all_o[e.dut], e.q, e.rise, e.fall, e.expd);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: stimulus did not complete, expected completion within 200000 time units");
        $fatal(1);
    end

    initial begin : stim
        for (int k = 0; k < N; k++) begin
            s_v[k] = 8'h00;
            r_v[k] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q1", q_o[1], 8'hA5);
        chk("rst_nq1", nq_o[1], 8'h5A);
        chk("rst_pulses1", rise_o[1] | fall_o[1] | expd_o[1], 8'h00);
        chk("rst_any_all1", {6'd0, any_o[1], all_o[1]}, 8'h02);
        chk("rst_q0", q_o[0], 8'h00);
        rst = 1'b0;

        // Clear INIT=A5, then reassert reset mid-cycle: the INIT value must return without a clock edge.
        step(1, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hA5, 8'h00);
        hold(1, 1, 8'h00);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_q1", q_o[1], 8'hA5);
        chk("async_nq1", nq_o[1], 8'h5A);
        chk("async_fall1", fall_o[1], 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // MODE1 (reset-dominant): s&r clears ch0 from 1, then holds it at 0.
        step(1, 8'h01, 8'h01, 8'hA4, 8'h00, 8'h01, 8'h00);
        step(1, 8'h01, 8'h01, 8'hA4, 8'h00, 8'h00, 8'h00);
        hold(1, 1, 8'hA4);

        // MODE2 (hold): s&r keeps whatever state ch0 already has.
        step(2, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
        step(2, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00);
        step(2, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
        step(2, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00);
        hold(2, 1, 8'h00);

        // MODE3 (toggle): three s&r cycles give 1,0,1.
        step(3, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00);
        step(3, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00);
        step(3, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00);
        hold(3, 2, 8'h01);

        // MODE0 (set-dominant) with timeout: s&r on ch0 sets; the flag expires after 4 high cycles.
        step(0, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00);
        hold(0, 3, 8'h01);
        step(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01);
        hold(0, 1, 8'h00);

        // A single set pulse on ch2 holds q high for exactly 4 cycles.
        step(0, 8'h04, 8'h00, 8'h04, 8'h04, 8'h00, 8'h00);
        hold(0, 3, 8'h04);
        step(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h04);
        hold(0, 1, 8'h00);

        // Retrigger during the second high cycle: 2 + 4 = 6 high cycles.
        step(0, 8'h04, 8'h00, 8'h04, 8'h04, 8'h00, 8'h00);
        step(0, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
        step(0, 8'h04, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
        hold(0, 3, 8'h04);
        step(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h04);
        hold(0, 1, 8'h00);

        // Same stimulus with RETRIGGER=0: 4 high cycles.
        step(4, 8'h04, 8'h00, 8'h04, 8'h04, 8'h00, 8'h00);
        step(4, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
        step(4, 8'h04, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
        hold(4, 1, 8'h04);
        step(4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h04);
        hold(4, 1, 8'h00);

        // External reset in the second high cycle: fall without expd.
        step(0, 8'h04, 8'h00, 8'h04, 8'h04, 8'h00, 8'h00);
        hold(0, 1, 8'h04);
        step(0, 8'h00, 8'h04, 8'h00, 8'h00, 8'h04, 8'h00);
        hold(0, 2, 8'h00);

        // A set in the same cycle as an expiry re-arms with a fresh timeout; q stays high.
        step(0, 8'h04, 8'h00, 8'h04, 8'h04, 8'h00, 8'h00);
        hold(0, 3, 8'h04);
        step(0, 8'h04, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
        hold(0, 3, 8'h04);
        step(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h04);
        hold(0, 1, 8'h00);

        // All channels set together, then r[7] alone; the rest time out.
        step(0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00);
        step(0, 8'h00, 8'h80, 8'h7F, 8'h00, 8'h80, 8'h00);
        hold(0, 2, 8'h7F);
        step(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h7F);
        hold(0, 1, 8'h00);

        stim_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
